// File: rtl/pll_drp_sequencer.sv
// pll_drp_sequencer
//   Runtime reconfiguration controller for a PLLE2_ADV driven through its DRP port.
//   It accepts a stream of read-modify-write ops (addr/mask/data/last) and holds the PLL
//   in reset while they run. After the op flagged last it releases reset and waits for a
//   synchronised LOCKED. It runs from the reference clock domain, never from a PLL output.
//
//   Ports
//     clk_i, rst_ni                 controller clock, async active-low reset
//     op_valid_i / op_ready_o       op handshake; fields op_addr_i, op_mask_i, op_data_i, op_last_i
//                                   (mask bit 1 keeps the read bit, 0 takes the op_data_i bit)
//     drp_den_o, drp_dwe_o,         DRP master side; den is a 1-cycle pulse
//     drp_daddr_o, drp_di_o,
//     drp_do_i, drp_drdy_i
//     pll_rst_o                     PLL RST, active high
//     pll_locked_i                  PLL LOCKED, asynchronous (2-FF synchronised here)
//     busy_o                        batch in progress
//     done_o                        1-cycle pulse: batch finished and PLL locked
//     err_o                         sticky DRDY/lock timeout or readback mismatch; cleared on next accept
//
//   Build option
//     PLL_DRP_READBACK_EN  re-reads each written register (VR/VR_WAIT states) and flags a
//                          mismatch; each op then costs 3 DRP accesses instead of 2.
module pll_drp_sequencer #(
    parameter int AWIDTH       = 7,
    parameter int DWIDTH       = 16,
    parameter int RST_HOLD     = 8,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 20000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic [AWIDTH-1:0] op_addr_i,
    input  logic [DWIDTH-1:0] op_mask_i,
    input  logic [DWIDTH-1:0] op_data_i,
    input  logic              op_last_i,
    output logic              drp_den_o,
    output logic              drp_dwe_o,
    output logic [AWIDTH-1:0] drp_daddr_o,
    output logic [DWIDTH-1:0] drp_di_o,
    input  logic [DWIDTH-1:0] drp_do_i,
    input  logic              drp_drdy_i,
    output logic              pll_rst_o,
    input  logic              pll_locked_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    localparam int CNT_MAX = (LOCK_TIMEOUT > DRDY_TIMEOUT)
                           ? ((LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD)
                           : ((DRDY_TIMEOUT > RST_HOLD) ? DRDY_TIMEOUT : RST_HOLD);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
    // The wait counter starts the cycle after den, so expiring at TIMEOUT-2 puts the
    // error flag exactly DRDY_TIMEOUT cycles after the den pulse.
    localparam logic [CW-1:0] DRDY_LAST = CW'(DRDY_TIMEOUT - 2);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] LOCK_MIN  = CW'(RST_HOLD);

`ifdef PLL_DRP_READBACK_EN
    typedef enum logic [3:0] {
        S_IDLE, S_RST_HOLD, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT, S_VR, S_VR_WAIT, S_NEXT, S_LOCK_WAIT
    } state_e;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_RST_HOLD, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT, S_NEXT, S_LOCK_WAIT
    } state_e;
`endif

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [DWIDTH-1:0]   mask_q, mask_d, data_q, data_d, wdata_q, wdata_d;
    logic                last_q, last_d;
    logic [1:0]          lock_sync_q, lock_sync_d;
    logic                seen_low_q, seen_low_d;
    logic                op_ready_q, op_ready_d, den_q, den_d, dwe_q, dwe_d;
    logic [AWIDTH-1:0]   daddr_q, daddr_d;
    logic [DWIDTH-1:0]   di_q, di_d;
    logic                pll_rst_q, pll_rst_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                accept;
    logic                lock_ok;

    assign accept  = op_valid_i & op_ready_q;
    // A lock that was already high at release is only trusted once it has been seen
    // low, or after LOCK_WAIT has lasted long enough for the PLL to have dropped it.
    assign lock_ok = lock_sync_q[1] & (seen_low_q | (cnt_q >= LOCK_MIN));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mask_d      = mask_q;
        data_d      = data_q;
        last_d      = last_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        done_d      = 1'b0;
        lock_sync_d = {lock_sync_q[0], pll_locked_i};

        if (accept) begin
            addr_d = op_addr_i;
            mask_d = op_mask_i;
            data_d = op_data_i;
            last_d = op_last_i;
            err_d  = 1'b0;
        end

        case (state_q)
            S_IDLE:     if (accept) state_d = S_RST_HOLD;
            S_RST_HOLD: if (cnt_q == HOLD_LAST) state_d = S_RD;
            S_RD:       state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (drp_drdy_i) begin
                    wdata_d = (drp_do_i & mask_q) | (data_q & ~mask_q);
                    state_d = S_WR;
                end else if (cnt_q == DRDY_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WR:       state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                if (drp_drdy_i) begin
`ifdef PLL_DRP_READBACK_EN
                    state_d = S_VR;
`else
                    state_d = last_q ? S_LOCK_WAIT : S_NEXT;
`endif
                end else if (cnt_q == DRDY_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
`ifdef PLL_DRP_READBACK_EN
            S_VR:       state_d = S_VR_WAIT;
            S_VR_WAIT: begin
                if (drp_drdy_i) begin
                    if (drp_do_i != wdata_q) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = last_q ? S_LOCK_WAIT : S_NEXT;
                    end
                end else if (cnt_q == DRDY_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
`endif
            S_NEXT:     if (accept) state_d = S_RD;
            S_LOCK_WAIT: begin
                if (lock_ok) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == LOCK_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default:    state_d = S_IDLE;
        endcase

        // Wait counter restarts on every state change and saturates otherwise.
        if (state_d != state_q)  cnt_d = '0;
        else if (cnt_q != '1)    cnt_d = cnt_q + CW'(1);
        else                     cnt_d = cnt_q;

        seen_low_d = (state_d != state_q) ? 1'b0
                   : (seen_low_q | ((state_q == S_LOCK_WAIT) & ~lock_sync_q[1]));

        // Outputs are registered from the next state so they line up with state_q.
        op_ready_d = (state_d == S_IDLE) || (state_d == S_NEXT);
        busy_d     = (state_d != S_IDLE);
        pll_rst_d  = busy_d && (state_d != S_LOCK_WAIT);
        den_d      = (state_d == S_RD) || (state_d == S_WR);
`ifdef PLL_DRP_READBACK_EN
        if (state_d == S_VR) den_d = 1'b1;
`endif
        dwe_d      = (state_d == S_WR);
        daddr_d    = den_d ? addr_d : '0;
        di_d       = dwe_d ? wdata_d : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            mask_q      <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            wdata_q     <= '0;
            lock_sync_q <= '0;
            seen_low_q  <= 1'b0;
            op_ready_q  <= 1'b1;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            daddr_q     <= '0;
            di_q        <= '0;
            pll_rst_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            data_q      <= data_d;
            last_q      <= last_d;
            wdata_q     <= wdata_d;
            lock_sync_q <= lock_sync_d;
            seen_low_q  <= seen_low_d;
            op_ready_q  <= op_ready_d;
            den_q       <= den_d;
            dwe_q       <= dwe_d;
            daddr_q     <= daddr_d;
            di_q        <= di_d;
            pll_rst_q   <= pll_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign op_ready_o  = op_ready_q;
    assign drp_den_o   = den_q;
    assign drp_dwe_o   = dwe_q;
    assign drp_daddr_o = daddr_q;
    assign drp_di_o    = di_q;
    assign pll_rst_o   = pll_rst_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_pll_drp_sequencer.sv
// Self-checking bench for pll_drp_sequencer: behavioural DRP register file and PLL lock
// model, a negedge monitor logging DRP traffic and output events, and a reference
// register image updated with the read-modify-write rule for every committed op.
module tb_pll_drp_sequencer;
`ifdef PLL_DRP_READBACK_EN
    localparam int ACC = 3;
`else
    localparam int ACC = 2;
`endif

    logic        clk, rst_ni;
    logic        op_valid_i, op_ready_o, op_last_i;
    logic [6:0]  op_addr_i;
    logic [15:0] op_mask_i, op_data_i;
    logic        drp_den_o, drp_dwe_o, drp_drdy_i;
    logic [6:0]  drp_daddr_o;
    logic [15:0] drp_di_o, drp_do_i;
    logic        pll_rst_o, pll_locked_i, busy_o, done_o, err_o;

    pll_drp_sequencer dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
        .op_addr_i(op_addr_i), .op_mask_i(op_mask_i), .op_data_i(op_data_i), .op_last_i(op_last_i),
        .drp_den_o(drp_den_o), .drp_dwe_o(drp_dwe_o), .drp_daddr_o(drp_daddr_o),
        .drp_di_o(drp_di_o), .drp_do_i(drp_do_i), .drp_drdy_i(drp_drdy_i),
        .pll_rst_o(pll_rst_o), .pll_locked_i(pll_locked_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { int cyc; logic we; logic [6:0] addr; logic [15:0] di; } den_rec_t;
    typedef struct { logic [6:0] addr; logic [15:0] data; } exp_wr_t;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // DRP register file (the "hardware") and the reference image
    logic [15:0] dmem [128];
    logic [15:0] emem [128];
    exp_wr_t     exp_wr [$];

    // model knobs
    int drp_lat = 0;          // 0 = random 1..8 per access
    bit drop_rd = 0;          // never answer reads
    bit corrupt = 0;          // flip bit 0 on second and later reads
    int rd_n = 0;
    int lock_delay = 50;
    bit lock_stuck = 0;

    // DRP slave + PLL model, driven just after the rising edge
    initial begin
        int pend;
        int lk_cnt;
        logic [15:0] pend_data;
        pend = 0; lk_cnt = 0; pend_data = '0;
        drp_drdy_i = 1'b0; drp_do_i = '0; pll_locked_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            drp_drdy_i = 1'b0;
            drp_do_i   = '0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    drp_drdy_i = 1'b1;
                    drp_do_i   = pend_data;
                end
            end
            if (drp_den_o && rst_ni) begin
                if (drp_dwe_o) begin
                    dmem[drp_daddr_o] = drp_di_o;
                    pend_data = '0;
                end else begin
                    rd_n++;
                    pend_data = dmem[drp_daddr_o] ^ ((corrupt && rd_n >= 2) ? 16'h0001 : 16'h0000);
                end
                if (drop_rd && !drp_dwe_o) pend = 0;
                else pend = (drp_lat != 0) ? drp_lat : int'($urandom_range(1, 8));
            end
            if (pll_rst_o) begin
                lk_cnt = 0;
                pll_locked_i = 1'b0;
            end else if (lock_stuck) begin
                pll_locked_i = 1'b0;
            end else begin
                if (lk_cnt < lock_delay) lk_cnt++;
                pll_locked_i = (lk_cnt >= lock_delay);
            end
        end
    end

    // Monitor: stable sampling on the falling edge
    int       cyc = 0, done_cnt = 0, err_rise_cyc = 0, acc_cyc = 0;
    int       rst_rise_cyc = 0, rst_fall_cyc = 0, rst_fall_cnt = 0;
    den_rec_t den_log [$];
    initial begin
        logic err_prev, rst_prev;
        err_prev = 1'b0; rst_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (drp_den_o) den_log.push_back('{cyc, drp_dwe_o, drp_daddr_o, drp_di_o});
            if (done_o) done_cnt++;
            if (err_o && !err_prev) err_rise_cyc = cyc;
            if (op_valid_i && op_ready_o) acc_cyc = cyc;
            if (pll_rst_o && !rst_prev) rst_rise_cyc = cyc;
            if (!pll_rst_o && rst_prev) begin
                rst_fall_cyc = cyc;
                rst_fall_cnt++;
            end
            err_prev = err_o;
            rst_prev = pll_rst_o;
        end
    end

    task automatic send_op(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                           input logic l, input bit upd);
        int n;
        n = 0;
        @(posedge clk); #1;
        op_valid_i = 1'b1; op_addr_i = a; op_mask_i = m; op_data_i = d; op_last_i = l;
        @(negedge clk);
        while (!op_ready_o && n < 30000) begin
            n++;
            @(negedge clk);
        end
        if (!op_ready_o) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        op_valid_i = 1'b0;
        if (upd) begin
            emem[a] = (emem[a] & m) | (d & ~m);
            exp_wr.push_back('{a, emem[a]});
        end
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_o && n < bound) begin
            n++;
            @(negedge clk);
        end
        if (busy_o) chk("idle_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_ready(input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (!op_ready_o && n < bound) begin
            n++;
            @(negedge clk);
        end
        if (!op_ready_o) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    int done0, fall0;
    task automatic start_batch();
        den_log.delete();
        exp_wr.delete();
        done0 = done_cnt;
        fall0 = rst_fall_cnt;
    endtask

    task automatic check_batch(input int n);
        chk("den_count", den_log.size(), ACC * n);
        if (den_log.size() == ACC * n && exp_wr.size() == n) begin
            for (int i = 0; i < n; i++) begin
                chk("rd_we",   den_log[ACC*i].we,     0);
                chk("rd_addr", den_log[ACC*i].addr,   exp_wr[i].addr);
                chk("wr_we",   den_log[ACC*i+1].we,   1);
                chk("wr_addr", den_log[ACC*i+1].addr, exp_wr[i].addr);
                chk("wr_data", den_log[ACC*i+1].di,   exp_wr[i].data);
`ifdef PLL_DRP_READBACK_EN
                chk("vr_we",   den_log[ACC*i+2].we,   0);
                chk("vr_addr", den_log[ACC*i+2].addr, exp_wr[i].addr);
`endif
            end
        end
    endtask

    initial begin
        int bad, n, last_den;
        logic [6:0] a3 [3];
        rst_ni = 1'b0;
        op_valid_i = 1'b0; op_addr_i = '0; op_mask_i = '0; op_data_i = '0; op_last_i = 1'b0;
        for (int i = 0; i < 128; i++) begin
            dmem[i] = 16'($urandom);
            emem[i] = dmem[i];
        end
        dmem[8] = 16'hF3C3;
        emem[8] = 16'hF3C3;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", op_ready_o, 1);
        chk("rst_den",   drp_den_o,  0);
        chk("rst_dwe",   drp_dwe_o,  0);
        chk("rst_plrst", pll_rst_o,  0);
        chk("rst_busy",  busy_o,     0);
        chk("rst_done",  done_o,     0);
        chk("rst_err",   err_o,      0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        repeat (60) @(posedge clk);

        // single directed op
        drp_lat = 2; lock_delay = 500;
        start_batch();
        send_op(7'h08, 16'h1000, 16'h0145, 1'b1, 1'b1);
        wait_idle(2000);
        check_batch(1);
        if (den_log.size() >= 2) begin
            chk("t1_di", den_log[1].di, 16'h1145);
            chk("t1_latency", den_log[0].cyc - acc_cyc, 9);
            chk("t1_rst_hold", (den_log[0].cyc - rst_rise_cyc) >= 8, 1);
        end
        chk("t1_done", done_cnt - done0, 1);
        chk("t1_err", err_o, 0);
        chk("t1_lock_time", (err_rise_cyc == 0) && (rst_fall_cnt - fall0 == 1), 1);

        // three-op batch with 5-cycle gaps in NEXT
        drp_lat = 0; lock_delay = 40;
        a3[0] = 7'h08; a3[1] = 7'h09; a3[2] = 7'h14;
        start_batch();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                wait_ready(200);
                repeat (5) @(posedge clk);
            end
            send_op(a3[i], 16'($urandom), 16'($urandom), i == 2, 1'b1);
        end
        wait_idle(2000);
        check_batch(3);
        chk("t2_done", done_cnt - done0, 1);
        chk("t2_one_release", rst_fall_cnt - fall0, 1);
        last_den = (den_log.size() > 0) ? den_log[den_log.size()-1].cyc : 0;
        chk("t2_release_after_last", rst_fall_cyc > last_den, 1);

        // read never answered -> DRDY timeout
        drop_rd = 1;
        start_batch();
        send_op(7'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b0);
        wait_idle(500);
        drop_rd = 0;
        chk("t3_den_count", den_log.size(), 1);
        if (den_log.size() >= 1) chk("t3_err_time", err_rise_cyc - den_log[0].cyc, 64);
        chk("t3_err",   err_o,      1);
        chk("t3_plrst", pll_rst_o,  0);
        chk("t3_ready", op_ready_o, 1);
        chk("t3_done",  done_cnt - done0, 0);
        repeat (20) @(posedge clk);

        // lock never comes -> lock timeout, then a clean batch clears err
        lock_stuck = 1;
        start_batch();
        send_op(7'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b1);
        wait_idle(21000);
        check_batch(1);
        chk("t4_err", err_o, 1);
        chk("t4_err_time", err_rise_cyc - rst_fall_cyc, 20000);
        chk("t4_done", done_cnt - done0, 0);
        lock_stuck = 0;
        start_batch();
        send_op(7'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b1);
        chk("t4_err_clear", err_o, 0);
        wait_idle(2000);
        check_batch(1);
        chk("t4_done2", done_cnt - done0, 1);
        chk("t4_err2", err_o, 0);

        // async reset during WR_WAIT, then a stale drdy
        drp_lat = 20;
        start_batch();
        send_op(7'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b1);
        n = 0;
        @(negedge clk);
        while (!(drp_den_o && drp_dwe_o) && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!(drp_den_o && drp_dwe_o)) chk("t5_write_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
        rst_ni = 1'b0;
        #1;
        chk("t5_ready", op_ready_o, 1);
        chk("t5_den",   drp_den_o,  0);
        chk("t5_dwe",   drp_dwe_o,  0);
        chk("t5_daddr", drp_daddr_o, 0);
        chk("t5_di",    drp_di_o,   0);
        chk("t5_plrst", pll_rst_o,  0);
        chk("t5_busy",  busy_o,     0);
        chk("t5_done",  done_o,     0);
        chk("t5_err",   err_o,      0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        n = den_log.size();
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy_o || drp_den_o || done_o) bad++;
        end
        chk("t5_stale_drdy", bad, 0);
        chk("t5_no_den", den_log.size(), n);
        drp_lat = 0;

        // readback corruption
        corrupt = 1; rd_n = 0; drp_lat = 3;
        start_batch();
        send_op(7'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b1);
        wait_idle(2000);
        corrupt = 0; drp_lat = 0;
        check_batch(1);
`ifdef PLL_DRP_READBACK_EN
        chk("t6_err",  err_o, 1);
        chk("t6_done", done_cnt - done0, 0);
        chk("t6_plrst", pll_rst_o, 0);
`else
        chk("t6_err",  err_o, 0);
        chk("t6_done", done_cnt - done0, 1);
`endif

        // randomized batches against the reference image
        for (int b = 0; b < 6; b++) begin
            n = int'($urandom_range(1, 4));
            lock_delay = int'($urandom_range(10, 150));
            start_batch();
            for (int i = 0; i < n; i++) begin
                if (i > 0) begin
                    wait_ready(200);
                    repeat ($urandom_range(0, 6)) @(posedge clk);
                end
                send_op(7'($urandom), 16'($urandom), 16'($urandom), i == n - 1, 1'b1);
            end
            wait_idle(5000);
            check_batch(n);
            chk("rnd_done", done_cnt - done0, 1);
            chk("rnd_err", err_o, 0);
            chk("rnd_release", rst_fall_cnt - fall0, 1);
        end

        bad = 0;
        for (int i = 0; i < 128; i++) if (dmem[i] !== emem[i]) bad++;
        chk("mem_final", bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
